// File: rtl/seven_segment_scan_driver_if.sv
// Bus bundle for seven_segment_scan_driver.
//   value[4*DIGITS-1:0] : hex nibbles, nibble i drives digit i
//   dp[DIGITS-1:0]      : decimal point per digit
//   load                : one-cycle strobe capturing value/dp into the shadow
//   blank_lz            : leading-zero blanking enable, sampled every cycle
//   abcdefg[6:0]        : shared segment bus, bit 6 = a ... bit 0 = g
//   dot                 : shared decimal-point segment
//   digit_en            : one-hot digit select
//   pending             : shadow holds a value not yet committed
//   frame_start         : pulse when digit 0 begins its lit phase
// The master drives the data side; the slave (the driver) drives the pins.
interface seven_segment_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_lz;
  logic [6:0]          abcdefg;
  logic                dot;
  logic [DIGITS-1:0]   digit_en;
  logic                pending;
  logic                frame_start;

  modport master (
    output value, dp, load, blank_lz,
    input  abcdefg, dot, digit_en, pending, frame_start
  );

  modport slave (
    input  value, dp, load, blank_lz,
    output abcdefg, dot, digit_en, pending, frame_start
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed driver for an N-digit seven-segment display.
// Digits share one segment bus and are lit one at a time for DWELL cycles,
// separated by GAP all-off cycles. A shadow register captures new values on
// load; they are committed to the displayed copy only when the scan wraps to
// digit 0, so a number never tears mid-frame.
// Ports:
//   clock   : clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of seven_segment_scan_driver_if (data in, pins out)
module seven_segment_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DWELL          = 12000,
  parameter int GAP            = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  seven_segment_scan_driver_if.slave bus
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [0:0] ST_SHOW = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  // Pin levels for "off"; XOR-ing an active-high value with these applies polarity.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    case (n)
      4'h0: decode_hex = 7'b1111110;
      4'h1: decode_hex = 7'b0110000;
      4'h2: decode_hex = 7'b1101101;
      4'h3: decode_hex = 7'b1111001;
      4'h4: decode_hex = 7'b0110011;
      4'h5: decode_hex = 7'b1011011;
      4'h6: decode_hex = 7'b1011111;
      4'h7: decode_hex = 7'b1110000;
      4'h8: decode_hex = 7'b1111111;
      4'h9: decode_hex = 7'b1111011;
      4'ha: decode_hex = 7'b1110111;
      4'hb: decode_hex = 7'b0011111;
      4'hc: decode_hex = 7'b1001110;
      4'hd: decode_hex = 7'b0111101;
      4'he: decode_hex = 7'b1001111;
      default: decode_hex = 7'b1000111;
    endcase
  endfunction

  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [0:0]          state_q, state_d;
  logic                first_q;
  logic [6:0]          seg_q, seg_d;
  logic                dot_q, dot_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                frame_start_q, frame_start_d;

  logic advance, idx_wrap, commit;

  // Scan sequencing, shadow capture and frame-boundary commit.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    advance  = 1'b0;
    idx_wrap = (int'(idx_q) == DIGITS - 1);

    case (state_q)
      ST_SHOW: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d = '0;
          if (GAP > 0) state_d = ST_GAP;
          else         advance = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          advance = 1'b1;
        end
      end
    endcase

    if (advance) idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);

    // Commit on the edge that wraps back to digit 0, and on the first edge out of reset.
    commit       = first_q || (advance && idx_wrap);
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (commit && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
    end

    // A load coinciding with a commit lands in the shadow after disp took the old one.
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp;
      pending_d    = 1'b1;
    end else if (commit) begin
      pending_d    = 1'b0;
    end
  end

  logic       show, lz_run, lz_sel, dot_sel, blank;
  logic [3:0] nib;

  // Pin values derived from the current state; they appear one cycle later.
  always_comb begin
    show    = (state_q == ST_SHOW);
    nib     = 4'h0;
    dot_sel = 1'b0;
    lz_sel  = 1'b0;
    lz_run  = 1'b1;
    digit_en_d = DIG_OFF;
    // Walk from the most significant digit down; lz_run stays set while every
    // nibble from the top down to digit i is zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp_val_q[4*i +: 4] == 4'h0);
      if (int'(idx_q) == i) begin
        nib     = disp_val_q[4*i +: 4];
        dot_sel = disp_dp_q[i];
        lz_sel  = lz_run;
        digit_en_d[i] = show ^ DIG_ACTIVE_LOW;
      end
    end
    // Digit 0 is never blanked so a zero value still shows "0".
    blank         = bus.blank_lz && (idx_q != '0) && lz_sel;
    seg_d         = ((show && !blank) ? decode_hex(nib) : 7'h00) ^ SEG_OFF;
    dot_d         = (show && dot_sel) ^ SEG_ACTIVE_LOW;
    frame_start_d = show && (idx_q == '0) && (cnt_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      state_q       <= ST_SHOW;
      first_q       <= 1'b1;
      seg_q         <= SEG_OFF;
      dot_q         <= SEG_ACTIVE_LOW;
      digit_en_q    <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      first_q       <= 1'b0;
      seg_q         <= seg_d;
      dot_q         <= dot_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.abcdefg     = seg_q;
  assign bus.dot         = dot_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;

endmodule
